// File: rtl/lcd_panel_detect.sv
// Power-up panel identification: releases the RGB bus, reads three strap pins,
// debounces the code over a sample window, and publishes the panel ID and resolution.
module lcd_panel_detect #(
  parameter int          SETTLE_CYCLES = 6,
  parameter int          SAMPLES       = 4,
  parameter int          MAX_RETRY     = 3,
  parameter logic [15:0] DEFAULT_ID    = 16'h4342
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redetect,
  input  logic [23:0] lcd_rgb,
  output logic        rgb_oe,
  output logic [15:0] lcd_id,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        id_valid,
  output logic        strap_err
);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SAMPLE = 2'd1,
    DECODE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] id;
    logic [10:0] h;
    logic [10:0] v;
  } panel_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [4:0] SAMPLE_LAST = 5'(SAMPLES - 1);
  localparam logic [3:0] RETRY_LAST  = 4'(MAX_RETRY - 1);

  state_t     state;
  logic [7:0] settle_cnt;
  logic [4:0] sample_cnt;
  logic [3:0] retry_cnt;
  logic [2:0] ref_code;
  logic       fallback;

  logic [2:0] strap_code;
  logic       mismatch;
  panel_t     panel;

  // Only one pin per colour lane carries a strap; the rest are plain pixel data.
  logic unused_rgb;
  assign unused_rgb = ^{lcd_rgb[22:16], lcd_rgb[14:8], lcd_rgb[6:0]};

  assign strap_code = {lcd_rgb[7], lcd_rgb[15], lcd_rgb[23]};

  // The first sample cycle loads the reference, so it can never mismatch.
  assign mismatch = (sample_cnt != 5'd0) && (strap_code != ref_code);

  function automatic panel_t decode_code(input logic [2:0] code);
    panel_t p;
    case (code)
      3'b000:  p = '{id: 16'h4342, h: 11'd480,  v: 11'd272};
      3'b001:  p = '{id: 16'h7084, h: 11'd800,  v: 11'd480};
      3'b010:  p = '{id: 16'h7016, h: 11'd1024, v: 11'd600};
      3'b100:  p = '{id: 16'h4384, h: 11'd800,  v: 11'd480};
      3'b101:  p = '{id: 16'h1018, h: 11'd1280, v: 11'd800};
      default: p = '{id: DEFAULT_ID, h: 11'd480, v: 11'd272};
    endcase
    return p;
  endfunction

  always_comb begin
    panel = decode_code(ref_code);
    if (fallback) panel = '{id: DEFAULT_ID, h: 11'd480, v: 11'd272};
  end

  // NOTE: every register here, including the reference code, is reset so that an
  // abort mid-window leaves no stale state behind for the restarted sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      sample_cnt <= '0;
      retry_cnt  <= '0;
      ref_code   <= '0;
      fallback   <= 1'b0;
      rgb_oe     <= 1'b0;
      id_valid   <= 1'b0;
      strap_err  <= 1'b0;
      lcd_id     <= '0;
      h_disp     <= '0;
      v_disp     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; every branch reads the
      // pre-edge values of the counters and state.
      case (state)
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end

        SAMPLE: begin
          if (sample_cnt == 5'd0) ref_code <= strap_code;
          if (mismatch) begin
            sample_cnt <= '0;
            if (retry_cnt == RETRY_LAST) begin
              fallback <= 1'b1;
              state    <= DECODE;
            end else begin
              retry_cnt  <= retry_cnt + 4'd1;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end else if (sample_cnt == SAMPLE_LAST) begin
            sample_cnt <= '0;
            state      <= DECODE;
          end else begin
            sample_cnt <= sample_cnt + 5'd1;
          end
        end

        DECODE: begin
          lcd_id    <= panel.id;
          h_disp    <= panel.h;
          v_disp    <= panel.v;
          strap_err <= fallback;
          id_valid  <= 1'b1;
          rgb_oe    <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          // ID and resolution stay visible until the next decode overwrites them.
          if (redetect) begin
            id_valid   <= 1'b0;
            rgb_oe     <= 1'b0;
            strap_err  <= 1'b0;
            retry_cnt  <= '0;
            fallback   <= 1'b0;
            settle_cnt <= '0;
            sample_cnt <= '0;
            state      <= SETTLE;
          end
        end

        default: state <= SETTLE;
      endcase
    end
  end

endmodule
